// File: rtl/mips8_ctrl_pkg.sv
// Shared encodings for the MIPS8 run controller and its memory arbiter.
// State codes, register map, CTRL bits and the memory-window select bit.
package mips8_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } run_state_e;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_DATA = 2'd2
  } host_phase_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CYCLES = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_RUN   = 0;
  localparam int CTRL_STEP  = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int MEM_WIN_BIT = 11;

  typedef struct packed {
    logic clear;
    logic step;
    logic run;
  } ctrl_cmd_t;

  function automatic ctrl_cmd_t decode_ctrl(
    input logic [2:0] d
  );
    ctrl_cmd_t c;
    c.run   = d[CTRL_RUN];
    c.step  = d[CTRL_STEP];
    c.clear = d[CTRL_CLEAR];
    return c;
  endfunction

endpackage

// File: rtl/mips8_mem_arb.sv
// Core/host memory port mux: core has fixed priority while it runs,
// and a starving host forces a one-cycle core stall to get the port.
module mips8_mem_arb
  import mips8_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_active,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_adr,
  input  logic [DATA_W-1:0] host_dat,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_dat,
  output logic              host_gnt,
  output logic              core_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdat
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] wait_cnt;
  logic          starved;
  logic          core_gnt;

  assign starved    = wait_cnt >= CW'(STARVE_MAX);
  assign core_stall = host_req && core_active
                   && core_req && starved;
  assign host_gnt   = host_req
                   && (!core_active || !core_req || starved);
  assign core_gnt   = core_active && core_req && !core_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!host_req || host_gnt) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_adr  = '0;
    mem_wdat = '0;
    if (host_gnt) begin
      mem_en   = 1'b1;
      mem_we   = host_we;
      mem_adr  = host_adr;
      mem_wdat = host_dat;
    end else if (core_gnt) begin
      mem_en   = 1'b1;
      mem_we   = core_we;
      mem_adr  = core_adr;
      mem_wdat = core_dat;
    end
  end

endmodule

// File: rtl/mips8_run_ctrl.sv
// Wishbone run controller for the MIPS8 core: reset/run/step/halt,
// host memory access and cycle count (counter built with MIPS8_CYCLE_CNT_EN).
module mips8_run_ctrl
  import mips8_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              core_rst_o,
  output logic              core_en_o,
  input  logic              core_halt_i,
  input  logic              core_mem_req_i,
  input  logic              core_mem_we_i,
  input  logic [ADDR_W-1:0] core_mem_adr_i,
  input  logic [DATA_W-1:0] core_mem_dat_i,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_adr_o,
  output logic [DATA_W-1:0] mem_wdat_o,
  input  logic [DATA_W-1:0] mem_rdat_i,
  output logic              irq_o
);

  run_state_e        state;
  run_state_e        state_nx;
  host_phase_e       hph;
  logic [ADDR_W-1:0] h_adr;
  logic [DATA_W-1:0] h_dat;
  logic              h_we;
  logic [31:0]       cycles;
  logic [31:0]       reg_rdata;
  logic              take;
  logic              is_mem;
  logic              irq_set;
  logic              core_active;
  logic              core_stall;
  logic              host_req;
  logic              host_gnt;
  ctrl_cmd_t         cmd;
  logic              unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_adr_i, wbs_dat_i};

  // one access outstanding; the ack cycle itself is never sampled
  assign take   = (hph == H_IDLE) && !wbs_ack_o
               && wbs_stb_i && wbs_cyc_i;
  assign is_mem = wbs_adr_i[MEM_WIN_BIT];
  assign cmd    = (take && !is_mem && wbs_we_i
                && wbs_adr_i[3:2] == REG_CTRL)
               ? decode_ctrl(wbs_dat_i[2:0]) : '0;

  assign core_active = (state == ST_RUN) || (state == ST_STEP);
  assign core_en_o   = core_active && !core_stall;
  assign core_rst_o  = (state == ST_HOLD);
  assign host_req    = (hph == H_WAIT) && wbs_cyc_i;

  mips8_mem_arb #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk         (wb_clk_i),
    .rst         (wb_rst_i),
    .core_active (core_active),
    .host_req    (host_req),
    .host_we     (h_we),
    .host_adr    (h_adr),
    .host_dat    (h_dat),
    .core_req    (core_mem_req_i),
    .core_we     (core_mem_we_i),
    .core_adr    (core_mem_adr_i),
    .core_dat    (core_mem_dat_i),
    .host_gnt    (host_gnt),
    .core_stall  (core_stall),
    .mem_en      (mem_en_o),
    .mem_we      (mem_we_o),
    .mem_adr     (mem_adr_o),
    .mem_wdat    (mem_wdat_o)
  );

  always_comb begin
    state_nx = state;
    irq_set  = 1'b0;
    unique case (state)
      ST_HOLD, ST_HALTED: begin
        if (cmd.run) begin
          state_nx = ST_RUN;
        end else if (cmd.step) begin
          state_nx = ST_STEP;
        end
      end
      ST_RUN: begin
        if (core_halt_i) begin
          state_nx = ST_HALTED;
          irq_set  = 1'b1;
        end
      end
      ST_STEP: begin
        // a stalled step cycle does not count as the step
        if (!core_stall) begin
          state_nx = ST_HALTED;
        end
      end
    endcase
    if (cmd.clear) begin
      state_nx = ST_HOLD;
      irq_set  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_HOLD;
      irq_o <= 1'b0;
    end else begin
      state <= state_nx;
      irq_o <= irq_set;
    end
  end

`ifdef MIPS8_CYCLE_CNT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cycles <= '0;
    end else if (cmd.clear) begin
      cycles <= '0;
    end else if (core_en_o && cycles != 32'hFFFF_FFFF) begin
      cycles <= cycles + 32'd1;
    end
  end
`else
  assign cycles = '0;
`endif

  always_comb begin
    reg_rdata = '0;
    case (wbs_adr_i[3:2])
      REG_STATUS: reg_rdata = {29'd0, hph == H_WAIT, state};
      REG_CYCLES: reg_rdata = cycles;
      default:    reg_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      hph       <= H_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      h_adr     <= '0;
      h_dat     <= '0;
      h_we      <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      case (hph)
        H_IDLE: begin
          if (take && is_mem) begin
            hph   <= H_WAIT;
            h_adr <= wbs_adr_i[ADDR_W+1:2];
            h_dat <= wbs_dat_i[DATA_W-1:0];
            h_we  <= wbs_we_i;
          end else if (take) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= wbs_we_i ? '0 : reg_rdata;
          end
        end
        H_WAIT: begin
          if (!wbs_cyc_i) begin
            hph <= H_IDLE;
          end else if (host_gnt) begin
            hph <= H_DATA;
          end
        end
        H_DATA: begin
          // a dropped cycle still lets a granted write land
          hph <= H_IDLE;
          if (wbs_cyc_i) begin
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= h_we ? '0 : 32'(mem_rdat_i);
          end
        end
        default: hph <= H_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips8_run_ctrl.sv
// Directed bench for mips8_run_ctrl: vector table for bus accesses,
// hand-written sequences for run/halt, step, starvation, clear, abort, reset.
module tb_mips8_run_ctrl;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_rst_o, core_en_o, core_halt_i;
  logic        core_mem_req_i, core_mem_we_i;
  logic [7:0]  core_mem_adr_i, core_mem_dat_i;
  logic        mem_en_o, mem_we_o;
  logic [7:0]  mem_adr_o, mem_wdat_o, mem_rdat_i;
  logic        irq_o;

  logic [7:0]  mem [256];

  int n_cmp = 0;
  int n_bad = 0;

`ifdef MIPS8_CYCLE_CNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [31:0] exp;
    int          lat;
    logic        is_mem;
    logic [7:0]  madr;
  } vec_t;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_adr_o] <= mem_wdat_o;
      mem_rdat_i <= mem[mem_adr_o];
    end
  end

  mips8_run_ctrl dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (wb_rst_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .core_rst_o     (core_rst_o),
    .core_en_o      (core_en_o),
    .core_halt_i    (core_halt_i),
    .core_mem_req_i (core_mem_req_i),
    .core_mem_we_i  (core_mem_we_i),
    .core_mem_adr_i (core_mem_adr_i),
    .core_mem_dat_i (core_mem_dat_i),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_adr_o      (mem_adr_o),
    .mem_wdat_o     (mem_wdat_o),
    .mem_rdat_i     (mem_rdat_i),
    .irq_o          (irq_o)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic [31:0] a, logic w,
                               logic [31:0] d, logic [31:0] e,
                               int l, logic m, logic [7:0] ma);
    vec_t v;
    v.adr = a; v.we = w; v.dat = d; v.exp = e;
    v.lat = l; v.is_mem = m; v.madr = ma;
    return v;
  endfunction

  // indices count negedges from the one where the request is driven
  task automatic wb_xfer(input logic [31:0] adr, input logic we,
                         input logic [31:0] dat,
                         output logic [31:0] rd, output int lat,
                         output int gidx, output logic [7:0] gadr,
                         output int en0);
    rd = '0; lat = -1; gidx = -1; gadr = '0; en0 = 0;
    @(negedge clk);
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!core_en_o && !core_rst_o) en0++;
      if (gidx < 0 && mem_en_o && !(core_en_o && core_mem_req_i)) begin
        gidx = i;
        gadr = mem_adr_o;
      end
      if (wbs_ack_o) begin
        lat = i;
        rd  = wbs_dat_o;
        break;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  vec_t        tv [12];
  logic [31:0] rd;
  logic [7:0]  gadr;
  int          lat, gidx, en0;
  int          acks, hg, esum, isum;

  initial begin
    wb_rst_i = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
    wbs_sel_i = 4'hF; wbs_adr_i = '0; wbs_dat_i = '0;
    core_halt_i = 0; core_mem_req_i = 0; core_mem_we_i = 0;
    core_mem_adr_i = 8'h55; core_mem_dat_i = 8'h00;

    tv[0]  = mkv(32'h004, 0, 0,            0,     1, 0, 0);
    tv[1]  = mkv(32'h000, 0, 0,            0,     1, 0, 0);
    tv[2]  = mkv(32'h008, 0, 0,            0,     1, 0, 0);
    tv[3]  = mkv(32'h80C, 1, 32'h0A5,      0,     3, 1, 8'h03);
    tv[4]  = mkv(32'h800, 1, 32'hFFFFFF5A, 0,     3, 1, 8'h00);
    tv[5]  = mkv(32'hBFC, 1, 32'h11,       0,     3, 1, 8'hFF);
    tv[6]  = mkv(32'h80C, 0, 0,            32'hA5, 3, 1, 8'h03);
    tv[7]  = mkv(32'h800, 0, 0,            32'h5A, 3, 1, 8'h00);
    tv[8]  = mkv(32'hBFC, 0, 0,            32'h11, 3, 1, 8'hFF);
    tv[9]  = mkv(32'h00C, 1, 32'hDEAD,     0,     1, 0, 0);
    tv[10] = mkv(32'h00C, 0, 0,            0,     1, 0, 0);
    tv[11] = mkv(32'h004, 0, 0,            0,     1, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst core_rst", core_rst_o, 1);
    chk("rst core_en", core_en_o, 0);
    chk("rst ack", wbs_ack_o, 0);
    chk("rst mem_en", mem_en_o, 0);
    chk("rst irq", irq_o, 0);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wb_xfer(tv[i].adr, tv[i].we, tv[i].dat, rd, lat, gidx, gadr, en0);
      chk($sformatf("tv%0d lat", i), lat, tv[i].lat);
      if (!tv[i].we) chk($sformatf("tv%0d data", i), rd, tv[i].exp);
      if (tv[i].is_mem) begin
        chk($sformatf("tv%0d grant", i), gidx, tv[i].lat - 2);
        chk($sformatf("tv%0d madr", i), gadr, tv[i].madr);
      end
    end

    // RUN, halt arrives in the 10th enabled cycle
    wb_xfer(32'h000, 1, 32'h1, rd, lat, gidx, gadr, en0);
    chk("run en", core_en_o, 1);
    chk("run rst", core_rst_o, 0);
    repeat (9) @(negedge clk);
    core_halt_i = 1'b1;
    @(negedge clk);
    core_halt_i = 1'b0;
    chk("halt irq", irq_o, 1);
    chk("halt en", core_en_o, 0);
    @(negedge clk);
    chk("irq width", irq_o, 0);
    wb_xfer(32'h004, 0, 0, rd, lat, gidx, gadr, en0);
    chk("halt state", rd, 3);
    wb_xfer(32'h008, 0, 0, rd, lat, gidx, gadr, en0);
    chk("run cycles", rd, CNT ? 10 : 0);

    // single step from HALTED
    wb_xfer(32'h000, 1, 32'h2, rd, lat, gidx, gadr, en0);
    esum = 0; isum = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      esum += int'(core_en_o);
      isum += int'(irq_o);
    end
    chk("step en cycles", esum, 1);
    chk("step irq", isum, 0);
    wb_xfer(32'h004, 0, 0, rd, lat, gidx, gadr, en0);
    chk("step state", rd, 3);
    wb_xfer(32'h008, 0, 0, rd, lat, gidx, gadr, en0);
    chk("step cycles", rd, CNT ? 11 : 0);

    // starvation: core hogs the port in RUN
    core_mem_req_i = 1'b1;
    wb_xfer(32'h000, 1, 32'h1, rd, lat, gidx, gadr, en0);
    wb_xfer(32'h80C, 0, 0, rd, lat, gidx, gadr, en0);
    chk("starve grant", gidx, 9);
    chk("starve madr", gadr, 8'h03);
    chk("starve ack", lat, 11);
    chk("starve data", rd, 32'hA5);
    chk("starve stalls", en0, 1);

    // host drops cyc while still waiting
    @(negedge clk);
    wbs_adr_i = 32'h800; wbs_we_i = 0;
    wbs_stb_i = 1; wbs_cyc_i = 1;
    acks = 0; hg = 0; en0 = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
      if (mem_en_o && mem_adr_o != 8'h55) hg++;
      if (!core_en_o) en0++;
      if (i == 3) begin
        wbs_stb_i = 0; wbs_cyc_i = 0;
      end
    end
    chk("abort ack", acks, 0);
    chk("abort grant", hg, 0);
    chk("abort stall", en0, 0);
    wb_xfer(32'h800, 0, 0, rd, lat, gidx, gadr, en0);
    chk("post abort lat", lat, 11);
    chk("post abort data", rd, 32'h5A);

    // CLEAR with RUN in the same write
    core_mem_req_i = 1'b0;
    wb_xfer(32'h000, 1, 32'h5, rd, lat, gidx, gadr, en0);
    chk("clear rst", core_rst_o, 1);
    chk("clear en", core_en_o, 0);
    wb_xfer(32'h004, 0, 0, rd, lat, gidx, gadr, en0);
    chk("clear state", rd, 0);
    wb_xfer(32'h008, 0, 0, rd, lat, gidx, gadr, en0);
    chk("clear cycles", rd, 0);

    // reset in the grant cycle of a memory read
    @(negedge clk);
    wbs_adr_i = 32'h80C; wbs_we_i = 0;
    wbs_stb_i = 1; wbs_cyc_i = 1;
    @(negedge clk);
    chk("mid grant", mem_en_o, 1);
    wb_rst_i = 1'b1;
    #1;
    chk("mid ack", wbs_ack_o, 0);
    chk("mid dat", wbs_dat_o, 0);
    chk("mid mem_en", mem_en_o, 0);
    chk("mid mem_we", mem_we_o, 0);
    chk("mid mem_adr", mem_adr_o, 0);
    chk("mid mem_wdat", mem_wdat_o, 0);
    chk("mid core_rst", core_rst_o, 1);
    chk("mid core_en", core_en_o, 0);
    chk("mid irq", irq_o, 0);
    wbs_stb_i = 0; wbs_cyc_i = 0;
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    chk("post rst ack", acks, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
